// File: rtl/core_mem_pkg.sv
// Shared types and sizing for the unified instruction/data memory arbiter.
package core_mem_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned AW_DEF    = 16;
    localparam int unsigned WORD_AW   = AW_DEF - 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INS  = 2'd1,
        OWN_DAT  = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; sat_o flags that fetch must win next.
module arb_starve_cnt #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_q) begin
            cnt_d = cnt_q + CW'(1);
        end
        sat_d = (cnt_d == CW'(MAX));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;

endmodule

// File: rtl/core_mem_arbiter.sv
// Arbitrates one single-port SRAM between fetch and data ports; data wins unless fetch is starved.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ins_req,
    input  logic [AW-1:0]        ins_a,
    output logic                 ins_gnt,
    output logic                 ins_rvalid,
    output logic [DW-1:0]        ins_rdata,
    input  logic                 dat_req,
    input  logic [AW-1:0]        dat_a,
    input  logic [NUM_LANES-1:0] dat_we,
    input  logic [DW-1:0]        dat_wd,
    output logic                 dat_gnt,
    output logic                 dat_rvalid,
    output logic [DW-1:0]        dat_rdata,
    output logic                 sram_e,
    output logic [NUM_LANES-1:0] sram_we,
    output logic [AW-3:0]        sram_a,
    output logic [DW-1:0]        sram_wd,
    input  logic [DW-1:0]        sram_rd
);

    logic   rdy_q;
    owner_e owner_q, owner_d;
    logic   starved;
    logic   unused_addr_lsbs;

    assign unused_addr_lsbs = ^{ins_a[1:0], dat_a[1:0]};

    arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rstn  (rstn),
        .inc_i (ins_req & ~ins_gnt),
        .clr_i (~ins_req | ins_gnt),
        .sat_o (starved)
    );

    // Grant decode and SRAM request mux; at most one grant per cycle.
    always_comb begin
        ins_gnt = rdy_q & ins_req & (~dat_req | starved);
        dat_gnt = rdy_q & dat_req & ~(ins_req & starved);
        sram_e  = ins_gnt | dat_gnt;
        sram_a  = dat_gnt ? dat_a[AW-1:2] : ins_a[AW-1:2];
        sram_we = dat_gnt ? dat_we : '0;
        sram_wd = dat_wd;

        owner_d = OWN_NONE;
        if (dat_gnt && (dat_we == '0)) begin
            owner_d = OWN_DAT;
        end else if (ins_gnt) begin
            owner_d = OWN_INS;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_q   <= 1'b0;
            owner_q <= OWN_NONE;
        end else begin
            rdy_q   <= 1'b1;
            owner_q <= owner_d;
        end
    end

    assign ins_rvalid = (owner_q == OWN_INS);
    assign dat_rvalid = (owner_q == OWN_DAT);
    assign ins_rdata  = sram_rd;
    assign dat_rdata  = sram_rd;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter with a behavioural 1-cycle SRAM and a reference memory.
module tb_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ins_req = 1'b0;
    logic [15:0] ins_a = '0;
    logic        ins_gnt, ins_rvalid;
    logic [31:0] ins_rdata;
    logic        dat_req = 1'b0;
    logic [15:0] dat_a = '0;
    logic [3:0]  dat_we = '0;
    logic [31:0] dat_wd = '0;
    logic        dat_gnt, dat_rvalid;
    logic [31:0] dat_rdata;
    logic        sram_e;
    logic [3:0]  sram_we;
    logic [13:0] sram_a;
    logic [31:0] sram_wd;
    logic [31:0] sram_rd = '0;

    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];

    logic [31:0] q_ins[$];
    logic [31:0] q_dat[$];

    int   n_checks = 0;
    int   n_errors = 0;
    bit   m_rdy = 1'b0;
    int   m_cnt = 0;
    int   m_own = 0;

    always #5 clk = ~clk;

    core_mem_arbiter #(.AW(16), .DW(32), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ins_req    (ins_req),
        .ins_a      (ins_a),
        .ins_gnt    (ins_gnt),
        .ins_rvalid (ins_rvalid),
        .ins_rdata  (ins_rdata),
        .dat_req    (dat_req),
        .dat_a      (dat_a),
        .dat_we     (dat_we),
        .dat_wd     (dat_wd),
        .dat_gnt    (dat_gnt),
        .dat_rvalid (dat_rvalid),
        .dat_rdata  (dat_rdata),
        .sram_e     (sram_e),
        .sram_we    (sram_we),
        .sram_a     (sram_a),
        .sram_wd    (sram_wd),
        .sram_rd    (sram_rd)
    );

    // SRAM macro stand-in: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (sram_e) begin
            if (sram_we == 4'b0000) begin
                sram_rd <= mem[sram_a];
            end else begin
                for (int l = 0; l < 4; l++) begin
                    if (sram_we[l]) mem[sram_a][8*l +: 8] <= sram_wd[8*l +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model, then step past the rising edge.
    task automatic step(input bit rst_mid);
        bit          e_sat, e_ig, e_dg;
        logic [31:0] exp_d;
        @(negedge clk);
        e_sat = (m_cnt == 4);
        e_ig  = m_rdy && ins_req && (!dat_req || e_sat);
        e_dg  = m_rdy && dat_req && !(ins_req && e_sat);
        chk("ins_gnt", 32'(ins_gnt), 32'(e_ig));
        chk("dat_gnt", 32'(dat_gnt), 32'(e_dg));
        chk("sram_e", 32'(sram_e), 32'(e_ig | e_dg));
        chk("sram_we", 32'(sram_we), e_dg ? 32'(dat_we) : 32'd0);
        if (e_dg) begin
            chk("sram_a_dat", 32'(sram_a), 32'(dat_a[15:2]));
            if (dat_we != 4'b0000) chk("sram_wd", sram_wd, dat_wd);
        end else if (e_ig) begin
            chk("sram_a_ins", 32'(sram_a), 32'(ins_a[15:2]));
        end
        chk("ins_rvalid", 32'(ins_rvalid), 32'(m_own == 1));
        chk("dat_rvalid", 32'(dat_rvalid), 32'(m_own == 2));
        if (m_own == 1) begin
            if (q_ins.size() == 0) chk("ins_q_empty", 32'd0, 32'd1);
            else chk("ins_rdata", ins_rdata, q_ins.pop_front());
        end
        if (m_own == 2) begin
            if (q_dat.size() == 0) chk("dat_q_empty", 32'd0, 32'd1);
            else chk("dat_rdata", dat_rdata, q_dat.pop_front());
        end
        chk("starve_le_max", 32'(dut.u_starve.cnt_q <= 3'd4), 32'd1);

        if (rst_mid) rstn = 1'b0;
        if (!rstn) begin
            m_rdy = 1'b0;
            m_cnt = 0;
            m_own = 0;
            q_ins.delete();
            q_dat.delete();
        end else begin
            m_own = 0;
            if (e_dg && dat_we == 4'b0000) begin
                m_own = 2;
                q_dat.push_back(ref_mem[dat_a[15:2]]);
            end else if (e_ig) begin
                m_own = 1;
                q_ins.push_back(ref_mem[ins_a[15:2]]);
            end
            if (e_dg && dat_we != 4'b0000) begin
                exp_d = ref_mem[dat_a[15:2]];
                for (int l = 0; l < 4; l++) begin
                    if (dat_we[l]) exp_d[8*l +: 8] = dat_wd[8*l +: 8];
                end
                ref_mem[dat_a[15:2]] = exp_d;
            end
            m_cnt = (ins_req && !e_ig) ? ((m_cnt == 4) ? 4 : m_cnt + 1) : 0;
            m_rdy = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
            ref_mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
        end
        mem[16]     = 32'h1122_3344;
        ref_mem[16] = 32'h1122_3344;

        // Reset held with both requesters active, then release: grants start on the second edge.
        ins_req = 1'b1; ins_a = 16'h0010;
        dat_req = 1'b1; dat_a = 16'h0020; dat_we = 4'b0000;
        for (int i = 0; i < 3; i++) step(1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0);
        ins_req = 1'b0; dat_req = 1'b0;
        step(1'b0);
        step(1'b0);

        // Fetch stream, one word per cycle.
        ins_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ins_a = 16'(4 * i);
            step(1'b0);
        end
        ins_req = 1'b0;
        step(1'b0);

        // Contention: four data grants then one fetch, repeating.
        ins_req = 1'b1; ins_a = 16'h0014;
        dat_req = 1'b1; dat_a = 16'h0028; dat_we = 4'b0000;
        for (int i = 0; i < 12; i++) step(1'b0);
        ins_req = 1'b0; dat_req = 1'b0;
        step(1'b0);

        // Single-lane write followed immediately by a read of the same word.
        dat_req = 1'b1; dat_a = 16'h0040; dat_we = 4'b0100; dat_wd = 32'h00AA_0000;
        step(1'b0);
        dat_we = 4'b0000; dat_wd = '0;
        step(1'b0);
        dat_req = 1'b0;
        step(1'b0);
        chk("byte_merge", ref_mem[16], 32'h11AA_3344);

        // Full write produces no read response.
        dat_req = 1'b1; dat_a = 16'h0030; dat_we = 4'b1111; dat_wd = 32'hDEAD_BEEF;
        step(1'b0);
        dat_req = 1'b0; dat_we = 4'b0000;
        step(1'b0);
        dat_req = 1'b1; dat_a = 16'h0030;
        step(1'b0);
        dat_req = 1'b0;
        step(1'b0);

        // Reset asserted while a read is in flight: its response must never appear.
        dat_req = 1'b1; dat_a = 16'h0008; dat_we = 4'b0000;
        step(1'b1);
        dat_req = 1'b0;
        step(1'b0);
        step(1'b0);
        rstn = 1'b1;
        step(1'b0);
        step(1'b0);
        step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
